// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package dmem_responder_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned byte address or address beyond the implemented word range.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    return ((addr & 32'(WORD_BYTES - 1)) != 32'd0) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_word_ram.sv
// Word-wide RAM: synchronous write, asynchronous read, no reset on contents.
module dmem_responder_word_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: req/ready handshake with WAIT_CYC wait states in front
// of a word RAM; the CPU stalls its MEM stage until mem_ready pulses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_d, err_out_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                ram_we_c;
  logic [ADDR_W-1:0]   ram_raddr_c;
  logic [DATA_W-1:0]   ram_rdata_c;
  logic                req_err_c;

  assign req_err_c = addr_err(mem_addr, ADDR_W);

  dmem_responder_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (Clock),
    .we      (ram_we_c),
    .waddr   (idx_q),
    .wdata   (wdata_q),
    .raddr   (ram_raddr_c),
    .rdata_c (ram_rdata_c)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      mem_ready <= ready_d;
      mem_err   <= err_out_d;
      mem_rdata <= rdata_d;
    end
  end

  // Next state and next outputs; response registers load on the edge into RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    err_d       = err_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    err_out_d   = 1'b0;
    rdata_d     = '0;
    ram_we_c    = 1'b0;
    ram_raddr_c = idx_q;

    case (state_q)
      IDLE: begin
        // With zero wait states the read goes straight from the live address.
        ram_raddr_c = mem_addr[ADDR_W+1:2];
        if (mem_req) begin
          we_d    = mem_we;
          err_d   = req_err_c;
          idx_d   = mem_addr[ADDR_W+1:2];
          wdata_d = mem_wdata;
          if (WAIT_CYC == 0) begin
            state_d   = RESP;
            ready_d   = 1'b1;
            err_out_d = req_err_c;
            if (!mem_we && !req_err_c) rdata_d = ram_rdata_c;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYC - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d   = RESP;
          ready_d   = 1'b1;
          err_out_d = err_q;
          if (!we_q && !err_q) rdata_d = ram_rdata_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d  = IDLE;
        ram_we_c = we_q & ~err_q;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 has WAIT_CYC=2, instance 1 WAIT_CYC=0.
module tb_dmem_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;

  logic        clk;
  logic        rstn  [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 0;

  dmem_responder #(.ADDR_W(6), .WAIT_CYC(2)) u_a (
    .Clock(clk), .Resetn(rstn[0]), .mem_req(req[0]), .mem_we(we[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_ready(ready[0]), .mem_err(err[0])
  );

  dmem_responder #(.ADDR_W(6), .WAIT_CYC(0)) u_b (
    .Clock(clk), .Resetn(rstn[1]), .mem_req(req[1]), .mem_we(we[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_ready(ready[1]), .mem_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=0x%08h want=0x%08h", name, s, cyc, act, exp);
    end
  endtask

  // Pops an expectation on every ready pulse; otherwise outputs must be zero.
  task automatic monitor(input int s);
    exp_t e;
    int   depth;
    if (ready[s] === 1'b1) begin
      depth = (s == 0) ? qa.size() : qb.size();
      if (depth == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready inst=%0d cyc=%0d got=1 want=0", s, cyc);
      end else begin
        e = (s == 0) ? qa.pop_front() : qb.pop_front();
        chk("resp_err",   s, 32'(err[s]), 32'(e.err));
        chk("resp_rdata", s, rdata[s], e.rdata);
        chk("resp_cycle", s, 32'(cyc), e.cyc);
      end
    end else begin
      chk("idle_ready", s, 32'(ready[s]), 32'd0);
      chk("idle_out",   s, {31'd0, err[s]} | rdata[s], 32'd0);
    end
  endtask

  always @(negedge clk) if (mon_en) monitor(0);
  always @(negedge clk) if (mon_en) monitor(1);

  task automatic push(input int s, input exp_t e);
    if (s == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic wait_ready(input int s);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready[s] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout inst=%0d cyc=%0d got=0 want=1", s, cyc);
    end
  endtask

  task automatic idle_bus(input int s);
    req[s]   = 1'b0;
    we[s]    = 1'($urandom);
    addr[s]  = $urandom;
    wdata[s] = $urandom;
  endtask

  // Issue one access at a negedge; keep=1 leaves req high into the next access.
  task automatic access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd, input bit keep);
    exp_t e;
    int   extra;
    extra    = (req[s] === 1'b1) ? 1 : 0;
    req[s]   = 1'b1;
    we[s]    = w;
    addr[s]  = a;
    wdata[s] = d;
    e.err    = e_err;
    e.rdata  = e_rd;
    e.cyc    = 32'(cyc + 1 + wc(s) + extra);
    push(0 + s, e);
    wait_ready(s);
    if (!keep) begin
      idle_bus(s);
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   nready;
    for (int s = 0; s < 2; s++) begin
      rstn[s] = 1'b0;
      idle_bus(s);
    end
    repeat (3) @(negedge clk);
    mon_en  = 1'b1;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    repeat (5) @(negedge clk);

    // Basic write then read with two wait states.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

    // Zero wait states, req held across ready: next access one cycle later.
    access(1, 1'b1, 32'h4, 32'h1, 1'b0, 32'h0, 1'b1);
    access(1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h1, 1'b0);
    access(1, 1'b1, 32'hFC, 32'h7777, 1'b0, 32'h0, 1'b0);
    access(1, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h7777, 1'b0);
    access(1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0);

    // Error accesses must not disturb words 0 and 1.
    access(0, 1'b1, 32'h0, 32'hA0A0A0A0, 1'b0, 32'h0, 1'b0);
    access(0, 1'b1, 32'h4, 32'h11111111, 1'b0, 32'h0, 1'b0);
    access(0, 1'b1, 32'h6, 32'h0000FFFF, 1'b1, 32'h0, 1'b0);
    access(0, 1'b1, 32'h400, 32'h0000EEEE, 1'b1, 32'h0, 1'b0);
    access(0, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0);
    access(0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h11111111, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA0A0A0A0, 1'b0);

    // Reset during WAIT aborts the write and suppresses ready.
    access(0, 1'b1, 32'h8, 32'h12345678, 1'b0, 32'h0, 1'b0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h55;
    @(negedge clk);
    rstn[0] = 1'b0;
    idle_bus(0);
    nready = 0;
    @(negedge clk);
    rstn[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) nready++;
    end
    chk("abort_no_ready", 0, 32'(nready), 32'd0);
    access(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h12345678, 1'b0);

    // Address/data changes during WAIT are ignored.
    access(0, 1'b1, 32'h18, 32'h18181818, 1'b0, 32'h0, 1'b0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'hCAFE0001;
    e.err = 1'b0; e.rdata = 32'h0; e.cyc = 32'(cyc + 3);
    push(0, e);
    @(negedge clk);
    addr[0]  = 32'h18;
    wdata[0] = 32'h00000BAD;
    wait_ready(0);
    idle_bus(0);
    @(negedge clk);
    access(0, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFE0001, 1'b0);
    access(0, 1'b0, 32'h18, 32'h0, 1'b0, 32'h18181818, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 0, 32'(qa.size() + qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
